// File: rtl/uart_boot_loader.sv
// UART boot loader: packs RX bytes into little-endian words, runs the READY/ACK
// handshake on the shared TX, then streams program words and input-data words.
//
// state      | meaning
// SEND_READY | waiting for TX idle to announce READY_BYTE
// RECV_SIZE  | assembling the program-size word (bytes)
// RECV_PROG  | assembling program words until the size target is reached
// SEND_ACK   | waiting for TX idle to send ACK_BYTE
// RUN        | terminal; every word is delivered as input data
module uart_boot_loader #(
    parameter logic [7:0] READY_BYTE     = 8'h99,
    parameter logic [7:0] ACK_BYTE       = 8'hAA,
    parameter int         MAX_PROG_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [7:0]  rdata,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  sdata,
    output logic        instr_ready,
    output logic        mem_ready,
    output logic [31:0] data,
    output logic        program_loaded,
    output logic        boot_error
);

    localparam logic [31:0] MAX_W = 32'(MAX_PROG_WORDS);

    typedef enum logic [2:0] {
        SEND_READY,
        RECV_SIZE,
        RECV_PROG,
        SEND_ACK,
        RUN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [31:0] word_cnt;
    logic [29:0] target;

    logic        byte_take;
    logic        word_done;
    logic [31:0] word_new;
    logic        tx_fire;
    logic [7:0]  tx_byte;
    logic        instr_fire;
    logic        mem_fire;

    // Bytes are only accepted once READY has gone out; earlier ones are line noise.
    assign byte_take = rx_ready && (state != SEND_READY);
    assign word_done = byte_take && (byte_cnt == 2'd3);
    assign word_new  = {rdata, shift};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SEND_READY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEND_READY: if (!tx_busy) state_nxt = RECV_SIZE;
            RECV_SIZE: begin
                if (word_done) begin
                    state_nxt = (word_new[31:2] == 30'd0) ? SEND_ACK : RECV_PROG;
                end
            end
            RECV_PROG: begin
                if (word_done && ((word_cnt + 32'd1) == {2'b00, target})) begin
                    state_nxt = SEND_ACK;
                end
            end
            SEND_ACK: if (!tx_busy) state_nxt = RUN;
            RUN:      state_nxt = RUN;
            default:  state_nxt = SEND_READY;
        endcase
    end

    always_comb begin
        tx_fire    = ((state == SEND_READY) || (state == SEND_ACK)) && !tx_busy;
        tx_byte    = (state == SEND_ACK) ? ACK_BYTE : READY_BYTE;
        // Words beyond the code segment capacity are swallowed without a pulse.
        instr_fire = word_done && (state == RECV_PROG) && (word_cnt < MAX_W);
        mem_fire   = word_done && ((state == SEND_ACK) || (state == RUN));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_cnt    <= 2'd0;
            shift       <= 24'd0;
            data        <= 32'd0;
            word_cnt    <= 32'd0;
            target      <= 30'd0;
            boot_error  <= 1'b0;
            instr_ready <= 1'b0;
            mem_ready   <= 1'b0;
            tx_start    <= 1'b0;
            sdata       <= 8'd0;
        end else begin
            if (byte_take) begin
                if (byte_cnt == 2'd3) begin
                    byte_cnt <= 2'd0;
                    data     <= word_new;
                end else begin
                    shift[8*byte_cnt +: 8] <= rdata;
                    byte_cnt               <= byte_cnt + 2'd1;
                end
            end
            if (word_done && (state == RECV_SIZE)) begin
                target <= word_new[31:2];
                if ({2'b00, word_new[31:2]} > MAX_W) begin
                    boot_error <= 1'b1;
                end
            end
            if (word_done && (state == RECV_PROG)) begin
                word_cnt <= word_cnt + 32'd1;
            end
            instr_ready <= instr_fire;
            mem_ready   <= mem_fire;
            tx_start    <= tx_fire;
            if (tx_fire) begin
                sdata <= tx_byte;
            end
        end
    end

    assign program_loaded = (state == RUN);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed byte streams, expected TX bytes and ready
// pulses queued as stimulus is issued and popped by a monitor on the falling edge.
module tb_uart_boot_loader;

    localparam int MAXW = 2;
    localparam int K_TX = 0;
    localparam int K_INSTR = 1;
    localparam int K_MEM = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rdata = 8'd0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  sdata;
    logic        instr_ready;
    logic        mem_ready;
    logic [31:0] data;
    logic        program_loaded;
    logic        boot_error;

    uart_boot_loader #(
        .READY_BYTE    (8'h99),
        .ACK_BYTE      (8'hAA),
        .MAX_PROG_WORDS(MAXW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_ready      (rx_ready),
        .rdata         (rdata),
        .tx_busy       (tx_busy),
        .tx_start      (tx_start),
        .sdata         (sdata),
        .instr_ready   (instr_ready),
        .mem_ready     (mem_ready),
        .data          (data),
        .program_loaded(program_loaded),
        .boot_error    (boot_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total = 0;
    int   busy_cnt = 0;
    logic prev_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic expect_evt(input int kind, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic pop_evt(input int kind, input logic [31:0] val);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            $display("FAIL unexpected_event: got kind %0d value %h, expected no event", kind, val);
        end else begin
            e = q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_value", val, e.val);
        end
    endtask

    // UART TX model: busy from the cycle after tx_start for 20 cycles.
    always @(negedge clock) begin
        if (busy_cnt > 0) busy_cnt--;
        if (tx_start) busy_cnt = 20;
    end
    always @(posedge clock) begin
        #1 tx_busy = (busy_cnt != 0);
    end

    always @(negedge clock) begin
        if (reset) begin
            if (tx_start) begin
                check("tx_while_busy", tx_busy, 1'b0);
                pop_evt(K_TX, {24'd0, sdata});
            end
            if (instr_ready || mem_ready) begin
                check("ready_exclusive", instr_ready & mem_ready, 1'b0);
                check("ready_back_to_back", prev_ready, 1'b0);
            end
            if (instr_ready) pop_evt(K_INSTR, data);
            if (mem_ready) pop_evt(K_MEM, data);
            prev_ready = instr_ready | mem_ready;
        end else begin
            prev_ready = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rdata    = b;
        rx_ready = 1'b1;
        @(posedge clock);
        #1;
        rx_ready = 1'b0;
        rdata    = 8'd0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clock);
        check("queue_drained", q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_loaded(input int budget);
        for (int i = 0; i < budget && !program_loaded; i++) @(negedge clock);
        check("program_loaded", program_loaded, 1'b1);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        rx_ready = 1'b0;
        @(negedge clock);
        check("reset_outputs", {tx_start, sdata, instr_ready, mem_ready, program_loaded, boot_error},
              12'd0);
        check("reset_data", data, 32'd0);
        expect_evt(K_TX, 32'h99);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        // Test 1: READY after reset, within two cycles.
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 3 && !seen; i++) begin
            @(negedge clock);
            seen = tx_start;
        end
        check("ready_latency", seen, 1'b1);
        wait_drain(10);

        // Test 2: size 8 bytes, two program words, ACK.
        send_word(32'h0000_0008);
        expect_evt(K_INSTR, 32'h0000_0013);
        expect_evt(K_INSTR, 32'h0123_4567);
        expect_evt(K_TX, 32'hAA);
        send_word(32'h0000_0013);
        send_word(32'h0123_4567);
        wait_loaded(100);
        wait_drain(10);
        check("boot_error_ok", boot_error, 1'b0);

        // Test 3: input-data word, pulse the cycle after the 4th byte.
        expect_evt(K_MEM, 32'hDEAD_BEEF);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        rdata    = 8'hDE;
        rx_ready = 1'b1;
        @(posedge clock);
        #1;
        rx_ready = 1'b0;
        check("mem_latency", mem_ready, 1'b1);
        check("mem_data", data, 32'hDEAD_BEEF);
        check("instr_quiet", instr_ready, 1'b0);
        wait_drain(10);

        // Test 4: zero-size program.
        do_reset();
        wait_drain(100);
        expect_evt(K_TX, 32'hAA);
        send_word(32'h0000_0000);
        wait_loaded(100);
        wait_drain(10);
        check("boot_error_zero", boot_error, 1'b0);
        expect_evt(K_MEM, 32'hCAFE_F00D);
        send_word(32'hCAFE_F00D);
        wait_drain(10);

        // Test 5: oversize program (MAXW=2 words, 3 sent).
        do_reset();
        wait_drain(100);
        send_word(32'h0000_000C);
        check("boot_error_set", boot_error, 1'b1);
        expect_evt(K_INSTR, 32'hA1A1_0001);
        expect_evt(K_INSTR, 32'hA2A2_0002);
        send_word(32'hA1A1_0001);
        send_word(32'hA2A2_0002);
        check("no_early_ack", program_loaded, 1'b0);
        expect_evt(K_TX, 32'hAA);
        send_word(32'hA3A3_0003);
        wait_loaded(100);
        wait_drain(10);
        check("boot_error_sticky", boot_error, 1'b1);
        expect_evt(K_MEM, 32'h1234_5678);
        send_word(32'h1234_5678);
        wait_drain(10);

        // Test 6: reset mid-word during program load.
        do_reset();
        wait_drain(100);
        send_word(32'h0000_0008);
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset();
        wait_drain(100);
        send_word(32'h0000_0004);
        expect_evt(K_INSTR, 32'h5566_7788);
        expect_evt(K_TX, 32'hAA);
        send_word(32'h5566_7788);
        wait_loaded(100);
        wait_drain(10);
        check("boot_error_after_reset", boot_error, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
